// File: rtl/tea_block_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tea_block_packer
//  Purpose  : Packs an 8-bit AXI-Stream message into 64-bit big-endian
//             plaintext blocks for the TEA core, padding the final partial
//             block of each message.
//  Options  : TEA_PACK_PKCS7_EN - PKCS#7 padding (pad value = pad count,
//             plus an extra 0x08 block for messages ending on a boundary).
//             Undefined: pad with PAD_BYTE, no extra block.
//  Revision : 1.0 - initial release
// ============================================================================
module tea_block_packer #(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_axis_valid_s,
    output logic             o_axis_ready_s,
    input  logic [7:0]       i_axis_data_s,
    input  logic             i_axis_last_s,
    output logic             o_axis_valid_m,
    input  logic             i_axis_ready_m,
    output logic [63:0]      o_axis_data_m,
    output logic             o_axis_last_m,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_block_count
);

`ifdef TEA_PACK_PKCS7_EN
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_OUT  = 2'd2,
        ST_XPAD = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;
`endif

    localparam logic [63:0] c_xpad_block = 64'h0808080808080808;

    state_t            r_state;
    logic [2:0]        r_byte_cnt;
    logic              r_ready;
    logic              r_valid;
    logic [63:0]       r_data;
    logic              r_last;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        w_pad_byte;

`ifdef TEA_PACK_PKCS7_EN
    logic              r_xpad;

    // In PAD, byte_cnt holds the number of filled lanes, so the pad count
    // (8 - byte_cnt) is simply its 3-bit negation.
    always_comb begin
        w_pad_byte = {5'd0, 3'd0 - r_byte_cnt};
    end
`else
    // Fixed fill byte when PKCS#7 is not built.
    always_comb begin
        w_pad_byte = PAD_BYTE;
    end
`endif

    // Packing state machine: byte capture, padding, and block hand-off.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_FILL;
            r_byte_cnt <= 3'd0;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 64'd0;
            r_last     <= 1'b0;
            r_count    <= '0;
`ifdef TEA_PACK_PKCS7_EN
            r_xpad     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_ready <= 1'b1;
                    if (i_axis_valid_s && r_ready) begin
                        // First byte of a block lands in the top lane.
                        for (int i = 0; i < 8; i++) begin
                            if (r_byte_cnt == 3'(i)) begin
                                r_data[63-8*i -: 8] <= i_axis_data_s;
                            end
                        end
                        if (r_byte_cnt == 3'd7) begin
                            r_byte_cnt <= 3'd0;
                            r_state    <= ST_OUT;
                            r_valid    <= 1'b1;
                            r_ready    <= 1'b0;
`ifdef TEA_PACK_PKCS7_EN
                            // A boundary-aligned message still owes a pad block,
                            // which then carries the last flag instead.
                            r_last     <= 1'b0;
                            r_xpad     <= i_axis_last_s;
`else
                            r_last     <= i_axis_last_s;
`endif
                        end else if (i_axis_last_s) begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                            r_state    <= ST_PAD;
                            r_last     <= 1'b1;
                            r_ready    <= 1'b0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                ST_PAD: begin
                    // Every lane at or beyond the fill count gets the pad value.
                    for (int i = 0; i < 8; i++) begin
                        if (3'(i) >= r_byte_cnt) begin
                            r_data[63-8*i -: 8] <= w_pad_byte;
                        end
                    end
                    r_byte_cnt <= 3'd0;
                    r_state    <= ST_OUT;
                    r_valid    <= 1'b1;
                end
                ST_OUT: begin
                    if (r_valid && i_axis_ready_m) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + CNT_W'(1);
`ifdef TEA_PACK_PKCS7_EN
                        if (r_xpad) begin
                            r_xpad  <= 1'b0;
                            r_state <= ST_XPAD;
                        end else begin
                            r_state <= ST_FILL;
                            r_ready <= 1'b1;
                        end
`else
                        r_state <= ST_FILL;
                        r_ready <= 1'b1;
`endif
                    end
                end
`ifdef TEA_PACK_PKCS7_EN
                ST_XPAD: begin
                    r_data  <= c_xpad_block;
                    r_last  <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= ST_OUT;
                end
`endif
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign o_axis_ready_s = r_ready;
    assign o_axis_valid_m = r_valid;
    assign o_axis_data_m  = r_data;
    assign o_axis_last_m  = r_last;
    assign o_block_count  = r_count;
    assign o_busy         = (r_state != ST_FILL) || (r_byte_cnt != 3'd0);

endmodule
`default_nettype wire

// File: doc/tea_block_packer.md
Name: tea_block_packer

Overview:
- Upstream feeder for the TEA encryption core: accepts an 8-bit AXI-Stream byte stream and packs it into 64-bit plaintext blocks.
- Pads the final partial block of each message, then presents blocks on a 64-bit AXI-Stream master.
- The master side connects directly to the core's i_axis_valid_s / o_axis_ready_s / i_axis_data_s.

Parameters:
- CNT_W, 16, width of o_block_count (wraps modulo 2^CNT_W)
- PAD_BYTE, 8'h00, fill byte used when PKCS#7 padding is compiled out

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_axis_valid_s  input  1  upstream byte valid
- o_axis_ready_s  output  1  packer can accept a byte
- i_axis_data_s  input  8  message byte
- i_axis_last_s  input  1  final byte of message
- o_axis_valid_m  output  1  packed block valid toward TEA core
- i_axis_ready_m  input  1  TEA core accepts block
- o_axis_data_m  output  64  packed block
- o_axis_last_m  output  1  block is last of message
- o_busy  output  1  partial block held or block pending
- o_block_count  output  CNT_W  blocks emitted since reset

Behaviour:
- Reset values:
  - o_axis_ready_s=0 in the cycle of reset; 1 on the first cycle after reset.
  - o_axis_valid_m=0, o_axis_data_m=0, o_axis_last_m=0, o_busy=0, o_block_count=0.
  - Byte counter=0, state=FILL.
- Reset mid-operation: any partial block or pending output is discarded with no flush.
- Byte order: the first byte of a block lands in [63:56], the eighth in [7:0] (big-endian; v1=[63:32], v0=[31:0] as the core splits them).
- States FILL, PAD, OUT, XPAD.
- FILL:
  - o_axis_ready_s=1. A byte transfers when valid_s&ready_s. It is written to the lane for byte_cnt (0..7), and byte_cnt increments.
  - 8th byte (byte_cnt==7): byte_cnt wraps to 0 and state goes to OUT. o_axis_last_m is set to i_axis_last_s.
  - last with byte_cnt<7: latch n = 7-byte_cnt remaining lanes, go to PAD, o_axis_last_m=1.
- PAD: one cycle, o_axis_ready_s=0. Fill the n empty low lanes with the pad value, clear byte_cnt, then go to OUT.
- OUT:
  - o_axis_ready_s=0, o_axis_valid_m=1.
  - o_axis_data_m and o_axis_last_m stay stable until valid_m&ready_m.
  - On the transfer: o_block_count increments.
  - Next state is XPAD if an extra pad block is owed (see Optional Feature); otherwise FILL.
  - The first byte of the next block can be accepted the cycle after the transfer; there is no same-cycle bypass.
- XPAD: one cycle; load 64'h0808080808080808 with last=1, then go to OUT.
- Latency: 8th byte accepted at cycle N gives valid_m high at N+1. A padded final block gives valid_m at N+2.
- Steady-state throughput: one block per 9 cycles with ready_m held high.
- i_axis_data_s is ignored when valid_s=0. The stream always carries ≥1 byte per message, so there is no empty-message case.
- Backpressure: ready_m held low keeps the packer in OUT indefinitely. ready_s stays 0 and no upstream bytes are lost.
- o_busy = (state!=FILL) | (byte_cnt!=0).
- o_block_count wraps silently at 2^CNT_W-1 → 0.

Optional Feature:
- Macro: TEA_PACK_PKCS7_EN.
- Defined:
  - Pad value = n, the number of pad bytes (1..7).
  - A message whose length is a multiple of 8 gets an extra block of eight 0x08 bytes via XPAD. In that case the data block carries last=0 and the XPAD block carries last=1.
- Undefined:
  - Pad value = PAD_BYTE.
  - A message that ends on a block boundary emits no extra block; that data block carries last=1.
  - The XPAD state is not built.

Test Plan:
- Reset, then bytes 01..08 with last on 08, ready_m=1 → one block 64'h0102030405060708, last=1 (PKCS7 off); valid_m rises 1 cycle after byte 08; o_block_count=1.
- Bytes AA,BB,CC with last on CC, PKCS7 on → block 64'hAABBCC0505050505, last=1; PKCS7 off, PAD_BYTE=00 → 64'hAABBCC0000000000.
- 8 bytes 11..18 with last on 18, PKCS7 on → 64'h1112131415161718 with last=0, then 64'h0808080808080808 with last=1; o_block_count=2.
- 16 bytes, ready_m held low 20 cycles after the first block → ready_s=0 throughout, data_m stable, no bytes lost; both blocks correct in order after release.
- Reset asserted after 5 bytes of a block → o_busy=0 next cycle. Fresh bytes 21..28 with last → block 64'h2122232425262728 with no residue.
- CNT_W=2: 5 blocks emitted → o_block_count sequence 1,2,3,0,1.
